mem_decipher: RTL and testbench

Streaming decipher for the modified Enigma datapath: accepts ciphertext ASCII bytes over a valid/ready handshake and recovers plaintext by applying the inverse of the substitution selected by `setting`. It sits on the receive side, downstream of the link that carries enciphering-engine output. It provides message framing, a two-stage pipeline with backpressure, a per-message character counter and optional rotor stepping.

---
 rtl/mem_pkg.sv | 44 ++++
 rtl/mem_inv_lookup.sv | 23 ++
 rtl/mem_decipher.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_decipher.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types, cipher-range constants, inverse substitution tables and FSM
// encoding for the mem_decipher receive path.
package mem_pkg;

    typedef logic [7:0] letter_t;
    typedef logic [4:0] code_t;
    typedef logic [1:0] set_t;

    localparam letter_t CIPHER_BASE = 8'h41;
    localparam int      CIPHER_SPAN = 32;
    localparam letter_t CIPHER_TOP  = CIPHER_BASE + 8'(CIPHER_SPAN - 1);

    // Inverses of the forward affine maps f(c) = (a*c + b) mod 32:
    // table 0 (3,14), table 1 identity, table 2 (5,7), table 3 (7,5).
    localparam code_t INV_TAB [0:3][0:31] = '{
        '{5'd6,  5'd17, 5'd28, 5'd7,  5'd18, 5'd29, 5'd8,  5'd19,
          5'd30, 5'd9,  5'd20, 5'd31, 5'd10, 5'd21, 5'd0,  5'd11,
          5'd22, 5'd1,  5'd12, 5'd23, 5'd2,  5'd13, 5'd24, 5'd3,
          5'd14, 5'd25, 5'd4,  5'd15, 5'd26, 5'd5,  5'd16, 5'd27},
        '{5'd0,  5'd1,  5'd2,  5'd3,  5'd4,  5'd5,  5'd6,  5'd7,
          5'd8,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15,
          5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
          5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31},
        '{5'd5,  5'd18, 5'd31, 5'd12, 5'd25, 5'd6,  5'd19, 5'd0,
          5'd13, 5'd26, 5'd7,  5'd20, 5'd1,  5'd14, 5'd27, 5'd8,
          5'd21, 5'd2,  5'd15, 5'd28, 5'd9,  5'd22, 5'd3,  5'd16,
          5'd29, 5'd10, 5'd23, 5'd4,  5'd17, 5'd30, 5'd11, 5'd24},
        '{5'd13, 5'd4,  5'd27, 5'd18, 5'd9,  5'd0,  5'd23, 5'd14,
          5'd5,  5'd28, 5'd19, 5'd10, 5'd1,  5'd24, 5'd15, 5'd6,
          5'd29, 5'd20, 5'd11, 5'd2,  5'd25, 5'd16, 5'd7,  5'd30,
          5'd21, 5'd12, 5'd3,  5'd26, 5'd17, 5'd8,  5'd31, 5'd22}
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic in_cipher_range(input letter_t b);
        return (b >= CIPHER_BASE) && (b <= CIPHER_TOP);
    endfunction

endpackage

// File: rtl/mem_inv_lookup.sv
// Combinational inverse substitution: cipher-range bytes are mapped through the
// selected inverse table, everything else passes through untouched.
module mem_inv_lookup
    import mem_pkg::*;
(
    input  set_t    set_i,
    input  letter_t letter_i,
    output letter_t letter_o
);

    code_t code_s;

    // Range check and table lookup
    always_comb begin
        code_s = letter_i[4:0] - CIPHER_BASE[4:0];
        if (in_cipher_range(letter_i)) begin
            letter_o = CIPHER_BASE + {3'b000, INV_TAB[set_i][code_s]};
        end else begin
            letter_o = letter_i;
        end
    end

endmodule

// File: rtl/mem_decipher.sv
// Streaming decipher top: message FSM, two-stage pipeline with backpressure and
// per-message letter counter. Define MEMDEC_STEP_EN to enable rotor stepping.
module mem_decipher
    import mem_pkg::*;
#(
    parameter int COUNT_W     = 16,
    parameter int STEP_PERIOD = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         setting,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_data,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [7:0]         m_data,
    output logic               m_last,
    output logic               busy,
    output logic [COUNT_W-1:0] count
);

    state_e             state_q, state_d;
    set_t               cur_set_q, cur_set_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               s1_valid_q, s1_valid_d;
    letter_t            s1_data_q, s1_data_d;
    logic               s1_last_q, s1_last_d;
    set_t               s1_set_q, s1_set_d;
    logic               m_valid_q, m_valid_d;
    letter_t            m_data_q, m_data_d;
    logic               m_last_q, m_last_d;
    logic               busy_q, busy_d;

    logic               s_ready_s;
    logic               s2_free_s;
    logic               s1_adv_s;
    logic               s_hs_s;
    logic               m_hs_s;
    logic               in_range_s;
    logic               open_s;
    logic               step_s;
    letter_t            plain_s;

    assign s2_free_s  = !m_valid_q || m_ready;
    assign s1_adv_s   = s1_valid_q && s2_free_s;
    assign s_hs_s     = s_valid && s_ready_s;
    assign m_hs_s     = m_valid_q && m_ready;
    assign in_range_s = in_cipher_range(s_data);
    assign open_s     = (state_q == ST_IDLE) && start;

    mem_inv_lookup u_lookup (
        .set_i    (s1_set_q),
        .letter_i (s1_data_q),
        .letter_o (plain_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (s_hs_s && s_last) state_d = ST_DRAIN;
                else                  state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (!s1_valid_q && !m_valid_q) state_d = ST_IDLE;
                else                           state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: input ready only while a message is open and stage 1 can take a byte
    always_comb begin
        s_ready_s = 1'b0;
        case (state_q)
            ST_RUN:  s_ready_s = !s1_valid_q || s1_adv_s;
            default: s_ready_s = 1'b0;
        endcase
    end

`ifdef MEMDEC_STEP_EN
    logic [7:0] step_cnt_q, step_cnt_d;
    logic       step_wrap_s;

    assign step_wrap_s = (step_cnt_q == 8'(STEP_PERIOD - 1));
    assign step_s      = s_hs_s && in_range_s && step_wrap_s;

    // Step counter next state: counts accepted cipher-range letters per rotor step
    always_comb begin
        step_cnt_d = step_cnt_q;
        if (open_s) begin
            step_cnt_d = 8'd0;
        end else if (s_hs_s && in_range_s) begin
            step_cnt_d = step_wrap_s ? 8'd0 : step_cnt_q + 8'd1;
        end else begin
            step_cnt_d = step_cnt_q;
        end
    end

    // Step counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_q <= 8'd0;
        end else begin
            step_cnt_q <= step_cnt_d;
        end
    end
`else
    logic unused_step_s;

    assign step_s        = 1'b0;
    assign unused_step_s = (STEP_PERIOD > 0);
`endif

    // Datapath next state: message setup, both pipeline stages, busy and counter
    always_comb begin
        cur_set_d  = cur_set_q;
        count_d    = count_q;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_last_d  = s1_last_q;
        s1_set_d   = s1_set_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        busy_d     = busy_q;

        if (open_s) begin
            cur_set_d = setting;
        end else if (step_s) begin
            cur_set_d = cur_set_q + 2'd1;
        end else begin
            cur_set_d = cur_set_q;
        end

        if (open_s) begin
            count_d = {COUNT_W{1'b0}};
        end else if (s_hs_s && in_range_s && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + COUNT_W'(1);
        end else begin
            count_d = count_q;
        end

        // Stage 1 captures the select in force at acceptance, before any step
        if (s_hs_s) begin
            s1_valid_d = 1'b1;
            s1_data_d  = s_data;
            s1_last_d  = s_last;
            s1_set_d   = cur_set_q;
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s2_free_s) begin
            m_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                m_data_d = plain_s;
                m_last_d = s1_last_q;
            end else begin
                m_data_d = m_data_q;
                m_last_d = m_last_q;
            end
        end else begin
            m_valid_d = m_valid_q;
        end

        if (open_s) begin
            busy_d = 1'b1;
        end else if (m_hs_s && m_last_q) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_set_q  <= 2'b00;
            count_q    <= {COUNT_W{1'b0}};
            s1_valid_q <= 1'b0;
            s1_data_q  <= 8'h00;
            s1_last_q  <= 1'b0;
            s1_set_q   <= 2'b00;
            m_valid_q  <= 1'b0;
            m_data_q   <= 8'h00;
            m_last_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cur_set_q  <= cur_set_d;
            count_q    <= count_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_last_q  <= s1_last_d;
            s1_set_q   <= s1_set_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            busy_q     <= busy_d;
        end
    end

    assign s_ready = s_ready_s;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;
    assign count   = count_q;

endmodule

// File: tb/tb_mem_decipher.sv
// Scoreboard bench for mem_decipher: directed messages push expected plaintext,
// a negedge monitor pops and compares every output handshake and checks stalls.
module tb_mem_decipher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  setting = 2'b00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic        m_last;
    logic        busy;
    logic [15:0] count;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [8:0]  exp_q[$];
    int          rdy_mode = 0;
    logic [15:0] rdy_pat = 16'b1001_0110_1100_1001;
    int          rdy_idx = 0;
    logic        flush = 1'b0;

    mem_decipher dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .setting (setting),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: brute-force inverse of the forward affine maps
    function automatic logic [7:0] model_plain(input logic [1:0] set, input logic [7:0] b);
        int a;
        int k;
        logic [7:0] r;
        case (set)
            2'd0:    begin a = 3; k = 14; end
            2'd1:    begin a = 1; k = 0;  end
            2'd2:    begin a = 5; k = 7;  end
            default: begin a = 7; k = 5;  end
        endcase
        r = b;
        if (b >= 8'h41 && b <= 8'h60) begin
            for (int c = 0; c < 32; c++) begin
                if (((a * c + k) % 32) == int'(b - 8'h41)) r = 8'h41 + 8'(c);
            end
        end
        return r;
    endfunction

    task automatic open_msg(input logic [1:0] s);
        @(posedge clk); #1;
        setting = s;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input logic [7:0] exp);
        int w;
        w = 0;
        exp_q.push_back({last, exp});
        s_valid = 1'b1;
        s_data  = b;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: byte 0x%0h never accepted", b);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (busy && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b, expected 0", busy);
        end
        repeat (3) @(posedge clk);
    endtask

    // m_ready driver: always-ready, pseudo-random pattern, or hard stall
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = rdy_pat[rdy_idx];
                    rdy_idx = (rdy_idx + 1) % 16;
                end
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops scoreboard on each output handshake, checks hold during stalls
    initial begin
        logic       stalled;
        logic [7:0] held_d;
        logic       held_l;
        logic [8:0] e;
        stalled = 1'b0;
        held_d  = 8'h00;
        held_l  = 1'b0;
        forever begin
            @(negedge clk);
            if (flush) begin
                stalled = 1'b0;
                flush   = 1'b0;
            end
            if (rst_n) begin
                if (stalled) begin
                    n_checks++;
                    if (!m_valid || m_data !== held_d || m_last !== held_l) begin
                        n_fail++;
                        $display("FAIL stall_hold: got v=%0b d=0x%0h l=%0b, expected v=1 d=0x%0h l=%0b",
                                 m_valid, m_data, m_last, held_d, held_l);
                    end
                end
                if (m_valid && m_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output: got d=0x%0h l=%0b, expected none", m_data, m_last);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_last, m_data} !== e) begin
                            n_fail++;
                            $display("FAIL output: got d=0x%0h l=%0b, expected d=0x%0h l=%0b",
                                     m_data, m_last, e[7:0], e[8]);
                        end
                    end
                end
                stalled = m_valid && !m_ready;
                held_d  = m_data;
                held_l  = m_last;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] stream [0:7];
        logic [1:0] ms;
        int         w;
        stream = '{8'h41, 8'h42, 8'h7A, 8'h48, 8'h60, 8'h40, 8'h4D, 8'h51};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 16'(s_ready), 16'd0);
        chk("rst_m_valid", 16'(m_valid), 16'd0);
        chk("rst_m_data",  16'(m_data),  16'h00);
        chk("rst_m_last",  16'(m_last),  16'd0);
        chk("rst_busy",    16'(busy),    16'd0);
        chk("rst_count",   count,        16'd0);
        #2 rst_n = 1'b1;

        // Single letter 'O' with table 0, latency and busy timing
        open_msg(2'b00);
        send_byte(8'h4F, 1'b1, 8'h41);
        @(negedge clk);
        chk("lat_n1_m_valid", 16'(m_valid), 16'd0);
        chk("lat_count",      count,        16'd1);
        @(negedge clk);
        chk("lat_n2_m_valid", 16'(m_valid), 16'd1);
        chk("lat_n2_m_data",  16'(m_data),  16'h41);
        chk("lat_n2_m_last",  16'(m_last),  16'd1);
        chk("lat_n2_busy",    16'(busy),    16'd1);
        @(negedge clk);
        chk("busy_fall",      16'(busy),    16'd0);
        repeat (3) @(posedge clk);

        // Table 3, 'F','F'
        open_msg(2'b11);
        send_byte(8'h46, 1'b0, 8'h41);
`ifdef MEMDEC_STEP_EN
        send_byte(8'h46, 1'b1, 8'h5E);
`else
        send_byte(8'h46, 1'b1, 8'h41);
`endif
        wait_idle();
        chk("ff_count", count, 16'd2);

        // Identity table with out-of-range bytes on both sides
        open_msg(2'b01);
        send_byte(8'h20, 1'b0, 8'h20);
        send_byte(8'h5A, 1'b0, 8'h5A);
        send_byte(8'h61, 1'b1, 8'h61);
        wait_idle();
        chk("pass_count", count, 16'd1);

        // Eight-byte stream against the reference model under m_ready pattern
        rdy_mode = 1;
        open_msg(2'b10);
        ms = 2'b10;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e;
            e = model_plain(ms, stream[i]);
`ifdef MEMDEC_STEP_EN
            if (stream[i] >= 8'h41 && stream[i] <= 8'h60) ms = ms + 2'd1;
`endif
            send_byte(stream[i], (i == 7), e);
        end
        wait_idle();
        rdy_mode = 0;
        chk("stream_count", count, 16'd6);

        // Reset with both stages full
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        open_msg(2'b00);
        send_byte(8'h4F, 1'b0, 8'h41);
        send_byte(8'h42, 1'b0, 8'h52);
        @(negedge clk);
        chk("full_m_valid", 16'(m_valid), 16'd1);
        chk("full_s_ready", 16'(s_ready), 16'd0);
        #2;
        rst_n = 1'b0;
        flush = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_m_valid", 16'(m_valid), 16'd0);
        chk("arst_m_data",  16'(m_data),  16'h00);
        chk("arst_busy",    16'(busy),    16'd0);
        chk("arst_count",   count,        16'd0);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        rdy_mode = 0;
        @(negedge clk);
        chk("arst_s_ready", 16'(s_ready), 16'd0);
        open_msg(2'b11);
        send_byte(8'h46, 1'b1, 8'h41);
        wait_idle();
        chk("post_rst_count", count, 16'd1);

        // start while RUN is ignored
        open_msg(2'b00);
        send_byte(8'h4F, 1'b0, 8'h41);
        open_msg(2'b11);
`ifdef MEMDEC_STEP_EN
        send_byte(8'h46, 1'b1, 8'h46);
`else
        send_byte(8'h46, 1'b1, 8'h5E);
`endif
        wait_idle();
        chk("run_start_count", count, 16'd2);

        // Drain scoreboard
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("sb_empty", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
